axi_ram_port_bridge: RTL and testbench
======================================

// Module: axi_ram_port_bridge
// PURPOSE
// AXI4 slave that turns the array's AXI master bursts (X/K reads, Y writes) into a simple RAM port.
// It sits between the top-level AXI master and the byte-addressed memory model / BRAM (ren/raddr/rdata, wen/waddr/wdata/wstrb).
// Read and write channels are independent and may be active in the same cycle.
// Word addresses on the RAM side are the AXI byte address >> LSB.
// PARAMETERS
// AXI_WIDTH       128  data width, bits; power of 2, >=32
// AXI_ADDR_WIDTH  32   AXI byte-address width
// AXI_ID_WIDTH    6    ID width; IDs are echoed on B and R
// RBUF_DEPTH      4    read-return FIFO depth, power of 2, >=4
// LSB             $clog2(AXI_WIDTH)-3  derived, do not override
// PORTS
// clk            in   1          clock; everything is on the rising edge
// rst            in   1          synchronous reset, active-high
// s_axi_aw{id,addr,len,valid}  in  ID/ADDR/8/1   write address; awsize=full width, INCR burst; burst/size/lock/cache/prot are not ported
// s_axi_awready  out  1          write address ready
// s_axi_w{data,strb,last,valid} in  W/W/8/1/1    write data (strb width W/8)
// s_axi_wready   out  1          write data ready
// s_axi_b{id,resp,valid} out ID/2/1              write response
// s_axi_bready   in   1          write response ready
// s_axi_ar{id,addr,len,valid} in  ID/ADDR/8/1    read address; same assumptions as AW
// s_axi_arready  out  1          read address ready
// s_axi_r{id,data,resp,last,valid} out ID/W/2/1/1 read data
// s_axi_rready   in   1          read data ready
// ren  out 1; raddr out ADDR-LSB; rdata in W   RAM read; rdata is valid in the cycle after ren
// wen  out 1; waddr out ADDR-LSB; wdata out W; wstrb out W/8   RAM write, committed at the clock edge
// BEHAVIOUR
// Reset values: awready=arready=0 during rst and 1 in the first cycle after it; all other outputs 0. FIFO is emptied and beat counters are cleared.
// Write FSM:
// - W_IDLE: awready=1. On AW handshake, capture id, word address (awaddr>>LSB) and len, then go to W_DATA.
// - W_DATA: wready=1. On each W handshake, in the next cycle drive wen=1 with the registered waddr/wdata/wstrb, then increment waddr.
// - The beat counter alone ends the burst (len+1 beats). wlast is ignored.
// - After the last W handshake go to W_RESP; bvalid rises in the same cycle as the last wen.
// - W_RESP: bvalid=1, bresp=OKAY, bid=captured id. Hold until bready; then go to W_IDLE.
// Read FSM:
// - R_IDLE: arready=1. On AR handshake, capture id, word address and len, then go to R_ISSUE.
// - R_ISSUE: drive ren=1 with raddr whenever fifo_count + inflight < RBUF_DEPTH; inflight counts ren pulses whose rdata has not yet been written into the FIFO.
// - Read pipeline: rdata that arrives in cycle c+1 (ren in c) is pushed with a last flag; rvalid no earlier than c+2.
// - After len+1 ren pulses go to R_DRAIN. On the R handshake with rlast=1, go to R_IDLE.
// - rresp=OKAY, rid=captured id.
// - Sustained rate is 1 beat/cycle when rready is held high.
// AXI rules:
// - rvalid/bvalid and their payloads stay stable until the handshake.
// - A burst of len=0 is a single beat.
// Address: increments by one word per beat and wraps modulo 2^(AXI_ADDR_WIDTH-LSB). No 4 KB boundary check.
// Simultaneous events:
// - ren and wen may assert in the same cycle.
// - Same-address read/write returns whatever the RAM model defines; the bridge does not forward.
// Backpressure: a low rready never loses or duplicates beats; FIFO overflow is impossible by construction.
// Reset mid-burst: the burst is abandoned, with no further wen/ren/rvalid/bvalid. The next AW/AR after reset starts cleanly.
// TESTING
// - AW addr=0x100,len=3 + 4 W beats, wstrb all-1 -> 4 wen at word 0x100>>LSB..+3, bvalid once, bresp=0, bid=awid.
// - AR addr=0x100,len=3 with rready=1 -> ren on 4 consecutive cycles; rdata matches the written data; rlast only on beat 4; rid=arid.
// - AR len=255 with rready randomly toggled (50%) -> exactly 256 beats in order, no duplicates, at most RBUF_DEPTH beats buffered.
// - Write with wstrb=0x000F on beat 1 -> only bytes 0-3 change in memory; a readback confirms the other bytes keep their old values.
// - AW and AR issued in the same cycle to different regions -> both complete, wen and ren overlap, data correct.
// - Assert rst for 1 cycle mid read burst (beat 2 of 8) -> no rvalid after reset; a following AR len=0 returns 1 correct beat.

Source files
------------

// File: rtl/axi_ram_port_bridge.sv
// AXI4 slave bridging full-width INCR bursts onto a single-cycle RAM read/write port.
// Latency: W beat -> wen next cycle; ren -> rdata next cycle -> rvalid the cycle after that.
// Backpressure: ren is throttled so FIFO + in-flight reads never exceed RBUF_DEPTH; bvalid held until bready.

// Small synchronous FIFO holding read returns; push is never issued when full.
module axi_ram_port_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_vld_i,
    input  logic [WIDTH-1:0]       in_dat_i,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [WIDTH-1:0]       out_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             pop;

    assign out_vld_o = (count_q != '0);
    assign pop       = out_vld_o & out_rdy_i;
    assign out_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (in_vld_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({in_vld_i, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until pushed
    always_ff @(posedge clk_i) begin
        if (in_vld_i) mem_q[wr_ptr_q] <= in_dat_i;
    end
endmodule

module axi_ram_port_bridge #(
    parameter  int AXI_WIDTH      = 128,
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_ID_WIDTH   = 6,
    parameter  int RBUF_DEPTH     = 4,
    localparam int LSB            = $clog2(AXI_WIDTH) - 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // write address
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr_i,
    input  logic [7:0]                    s_axi_awlen_i,
    input  logic                          s_axi_awvalid_i,
    output logic                          s_axi_awready_o,
    // write data
    input  logic [AXI_WIDTH-1:0]          s_axi_wdata_i,
    input  logic [AXI_WIDTH/8-1:0]        s_axi_wstrb_i,
    input  logic                          s_axi_wlast_i,
    input  logic                          s_axi_wvalid_i,
    output logic                          s_axi_wready_o,
    // write response
    output logic [AXI_ID_WIDTH-1:0]       s_axi_bid_o,
    output logic [1:0]                    s_axi_bresp_o,
    output logic                          s_axi_bvalid_o,
    input  logic                          s_axi_bready_i,
    // read address
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr_i,
    input  logic [7:0]                    s_axi_arlen_i,
    input  logic                          s_axi_arvalid_i,
    output logic                          s_axi_arready_o,
    // read data
    output logic [AXI_ID_WIDTH-1:0]       s_axi_rid_o,
    output logic [AXI_WIDTH-1:0]          s_axi_rdata_o,
    output logic [1:0]                    s_axi_rresp_o,
    output logic                          s_axi_rlast_o,
    output logic                          s_axi_rvalid_o,
    input  logic                          s_axi_rready_i,
    // RAM port
    output logic                          ren_o,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] raddr_o,
    input  logic [AXI_WIDTH-1:0]          rdata_i,
    output logic                          wen_o,
    output logic [AXI_ADDR_WIDTH-LSB-1:0] waddr_o,
    output logic [AXI_WIDTH-1:0]          wdata_o,
    output logic [AXI_WIDTH/8-1:0]        wstrb_o
);
    localparam int RAW = AXI_ADDR_WIDTH - LSB;
    localparam int SW  = AXI_WIDTH / 8;
    localparam int CW  = $clog2(RBUF_DEPTH) + 1;
    localparam int OW  = CW + 1;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ISSUE = 2'd1, R_DRAIN = 2'd2} rd_state_e;

    // ------------------------------------------------------------------ write side
    wr_state_e             wr_state_q, wr_state_d;
    logic [AXI_ID_WIDTH-1:0] wr_id_q;
    logic [7:0]            wr_len_q;
    logic [7:0]            wr_cnt_q;
    logic [RAW-1:0]        wr_ptr_q;
    logic                  wen_q;
    logic [RAW-1:0]        waddr_q;
    logic [AXI_WIDTH-1:0]  wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs = s_axi_awvalid_i & s_axi_awready_o;
    assign w_hs  = s_axi_wvalid_i & s_axi_wready_o;

    // Write FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) wr_state_q <= W_IDLE;
        else       wr_state_q <= wr_state_d;
    end

    // Write FSM next state: the beat counter alone ends the burst
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
            W_DATA:  if (w_hs && (wr_cnt_q == wr_len_q)) wr_state_d = W_RESP;
            W_RESP:  if (s_axi_bready_i) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs, all forced low while reset is asserted
    always_comb begin
        s_axi_awready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        s_axi_bvalid_o  = 1'b0;
        if (!rst_i) begin
            case (wr_state_q)
                W_IDLE:  s_axi_awready_o = 1'b1;
                W_DATA:  s_axi_wready_o  = 1'b1;
                W_RESP:  s_axi_bvalid_o  = 1'b1;
                default: ;
            endcase
        end
    end

    // Burst capture and one-cycle registered RAM write per accepted beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_id_q  <= '0;
            wr_len_q <= '0;
            wr_cnt_q <= '0;
            wr_ptr_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            wen_q <= w_hs;
            if (aw_hs) begin
                wr_id_q  <= s_axi_awid_i;
                wr_len_q <= s_axi_awlen_i;
                wr_cnt_q <= '0;
                wr_ptr_q <= s_axi_awaddr_i[AXI_ADDR_WIDTH-1:LSB];
            end
            if (w_hs) begin
                waddr_q  <= wr_ptr_q;
                wdata_q  <= s_axi_wdata_i;
                wstrb_q  <= s_axi_wstrb_i;
                wr_ptr_q <= wr_ptr_q + RAW'(1);
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
        end
    end

    assign wen_o         = wen_q & ~rst_i;
    assign waddr_o       = waddr_q;
    assign wdata_o       = wdata_q;
    assign wstrb_o       = wstrb_q;
    assign s_axi_bid_o   = wr_id_q;
    assign s_axi_bresp_o = 2'b00;

    // ------------------------------------------------------------------ read side
    rd_state_e             rd_state_q, rd_state_d;
    logic [AXI_ID_WIDTH-1:0] rd_id_q;
    logic [7:0]            rd_len_q;
    logic [7:0]            rd_cnt_q;
    logic [RAW-1:0]        rd_ptr_q;
    logic                  rd_inflight_q;
    logic                  rd_last_pend_q;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rd_room;
    logic                  fifo_vld;
    logic [AXI_WIDTH:0]    fifo_head;
    logic [CW-1:0]         fifo_cnt;

    assign ar_hs   = s_axi_arvalid_i & s_axi_arready_o;
    assign r_hs    = s_axi_rvalid_o & s_axi_rready_i;
    // A read may only be issued if its return is guaranteed a FIFO slot
    assign rd_room = ({1'b0, fifo_cnt} + OW'(rd_inflight_q)) < OW'(RBUF_DEPTH);

    // Read FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_state_q <= R_IDLE;
        else       rd_state_q <= rd_state_d;
    end

    // Read FSM next state: issue len+1 reads, then wait for the last beat to leave
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_ISSUE;
            R_ISSUE: if (ren_o && (rd_cnt_q == rd_len_q)) rd_state_d = R_DRAIN;
            R_DRAIN: if (r_hs && s_axi_rlast_o) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs, all forced low while reset is asserted
    always_comb begin
        s_axi_arready_o = 1'b0;
        ren_o           = 1'b0;
        if (!rst_i) begin
            case (rd_state_q)
                R_IDLE:  s_axi_arready_o = 1'b1;
                R_ISSUE: ren_o           = rd_room;
                default: ;
            endcase
        end
    end

    // Burst capture, read address walk and in-flight tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_id_q        <= '0;
            rd_len_q       <= '0;
            rd_cnt_q       <= '0;
            rd_ptr_q       <= '0;
            rd_inflight_q  <= 1'b0;
            rd_last_pend_q <= 1'b0;
        end else begin
            rd_inflight_q <= ren_o;
            if (ar_hs) begin
                rd_id_q  <= s_axi_arid_i;
                rd_len_q <= s_axi_arlen_i;
                rd_cnt_q <= '0;
                rd_ptr_q <= s_axi_araddr_i[AXI_ADDR_WIDTH-1:LSB];
            end
            if (ren_o) begin
                rd_ptr_q       <= rd_ptr_q + RAW'(1);
                rd_cnt_q       <= rd_cnt_q + 8'd1;
                rd_last_pend_q <= (rd_cnt_q == rd_len_q);
            end
        end
    end

    assign raddr_o = rd_ptr_q;

    axi_ram_port_bridge_fifo #(
        .WIDTH (AXI_WIDTH + 1),
        .DEPTH (RBUF_DEPTH)
    ) u_rbuf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_vld_i  (rd_inflight_q),
        .in_dat_i  ({rd_last_pend_q, rdata_i}),
        .out_vld_o (fifo_vld),
        .out_rdy_i (s_axi_rready_i & ~rst_i),
        .out_dat_o (fifo_head),
        .count_o   (fifo_cnt)
    );

    assign s_axi_rvalid_o = fifo_vld & ~rst_i;
    assign s_axi_rlast_o  = s_axi_rvalid_o & fifo_head[AXI_WIDTH];
    assign s_axi_rdata_o  = s_axi_rvalid_o ? fifo_head[AXI_WIDTH-1:0] : '0;
    assign s_axi_rid_o    = rd_id_q;
    assign s_axi_rresp_o  = 2'b00;

    // wlast and sub-word address bits carry no information for full-width INCR bursts
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_wlast_i,
                         s_axi_awaddr_i[LSB-1:0], s_axi_araddr_i[LSB-1:0]};
endmodule

// File: tb/tb_axi_ram_port_bridge.sv
// Directed scenarios with random data, checked against a word-level memory reference model.
module tb_axi_ram_port_bridge;
    localparam int W     = 128;
    localparam int AW    = 32;
    localparam int IDW   = 6;
    localparam int DEPTH = 4;
    localparam int LSB   = 4;
    localparam int SW    = W / 8;
    localparam int RAW   = AW - LSB;
    localparam int unsigned AMASK = (32'h1 << RAW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
    logic [AW-1:0]  awaddr = '0, araddr = '0;
    logic [7:0]     awlen = '0, arlen = '0;
    logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic arvalid = 1'b0, arready, bvalid, bready = 1'b0;
    logic rvalid, rready = 1'b0, rlast;
    logic [W-1:0]   wdata_in = '0, rdata_out, rdata = '0, wdata;
    logic [SW-1:0]  wstrb_in = '0, wstrb;
    logic [1:0]     bresp, rresp;
    logic           ren, wen;
    logic [RAW-1:0] raddr, waddr;

    axi_ram_port_bridge #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .RBUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
        .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata_in), .s_axi_wstrb_i(wstrb_in), .s_axi_wlast_i(wlast),
        .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
        .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
        .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen),
        .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
        .s_axi_rid_o(rid), .s_axi_rdata_o(rdata_out), .s_axi_rresp_o(rresp),
        .s_axi_rlast_o(rlast), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
        .ren_o(ren), .raddr_o(raddr), .rdata_i(rdata),
        .wen_o(wen), .waddr_o(waddr), .wdata_o(wdata), .wstrb_o(wstrb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM behind the bridge, and the reference memory built from AXI transactions
    logic [W-1:0] ram     [int unsigned];
    logic [W-1:0] ref_mem [int unsigned];
    logic [W-1:0] ram_w;

    logic [W-1:0]  wd [256];
    logic [SW-1:0] ws [256];

    logic [RAW-1:0] wl_addr [$];
    logic [W-1:0]   wl_data [$];
    logic [SW-1:0]  wl_strb [$];
    logic [W-1:0]   rl_data [$];
    logic           rl_last [$];
    logic [IDW-1:0] rl_id   [$];
    logic [1:0]     rl_resp [$];
    logic [RAW-1:0] rn_addr [$];
    int             rn_cyc  [$];
    int cyc = 0, ren_n = 0, acc_n = 0, rv_n = 0, ovl_n = 0;
    logic rand_rr = 1'b0;

    function automatic logic [W-1:0] ram_rd(input int unsigned a);
        if (ram.exists(a)) return ram[a];
        return '0;
    endfunction

    function automatic logic [W-1:0] ref_get(input int unsigned a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return '0;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Bench RAM: read data one cycle after ren, byte-enabled write at the edge
    always @(posedge clk) begin
        if (ren) rdata <= ram_rd(int'(raddr));
        if (wen) begin
            ram_w = ram_rd(int'(waddr));
            for (int b = 0; b < SW; b++)
                if (wstrb[b]) ram_w[b*8 +: 8] = wdata[b*8 +: 8];
            ram[int'(waddr)] = ram_w;
        end
    end

    // Passive monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (wen) begin
            wl_addr.push_back(waddr); wl_data.push_back(wdata); wl_strb.push_back(wstrb);
        end
        if (ren) begin
            ren_n++; rn_addr.push_back(raddr); rn_cyc.push_back(cyc);
        end
        if (rvalid) rv_n++;
        if (rvalid && rready) begin
            acc_n++;
            rl_data.push_back(rdata_out); rl_last.push_back(rlast);
            rl_id.push_back(rid); rl_resp.push_back(rresp);
        end
        if (wen && ren) ovl_n++;
    end

    // R-channel consumer: always ready, or a 50% random pattern
    always @(posedge clk) begin
        #1;
        rready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Apply the staged write burst to the reference memory
    task automatic ref_write(input int unsigned addr, input int len);
        int unsigned a;
        logic [W-1:0] v;
        for (int i = 0; i <= len; i++) begin
            a = ((addr >> LSB) + i) & AMASK;
            v = ref_get(a);
            for (int b = 0; b < SW; b++)
                if (ws[i][b]) v[b*8 +: 8] = wd[i][b*8 +: 8];
            ref_mem[a] = v;
        end
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input int unsigned addr, input int len);
        int n;
        int k;
        int unsigned base;
        base = addr >> LSB;
        wl_addr.delete(); wl_data.delete(); wl_strb.delete();
        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin tick(); n++; end
        check("aw_ready", awready, 1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata_in = wd[i]; wstrb_in = ws[i]; wlast = (i == len);
            n = 0;
            while (wready !== 1'b1 && n < 50) begin tick(); n++; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("bvalid_with_last_wen", {wen, bvalid}, 2'b11);
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
        k = $urandom_range(0, 3);
        repeat (k) tick();
        check("bvalid_held", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_after_hs", bvalid, 0);
        check("wen_count", wl_addr.size(), len + 1);
        for (int i = 0; i <= len && i < wl_addr.size(); i++) begin
            check($sformatf("waddr[%0d]", i), wl_addr[i], (base + i) & AMASK);
            check($sformatf("wdata[%0d]", i), wl_data[i], wd[i]);
            check($sformatf("wstrb[%0d]", i), wl_strb[i], ws[i]);
        end
        ref_write(addr, len);
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input int unsigned addr, input int len,
                            input logic consec);
        int n;
        int out0;
        int maxo;
        int unsigned base;
        base = addr >> LSB;
        rl_data.delete(); rl_last.delete(); rl_id.delete(); rl_resp.delete();
        rn_addr.delete(); rn_cyc.delete();
        out0 = ren_n - acc_n;
        maxo = 0;
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin tick(); n++; end
        check("ar_ready", arready, 1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (rl_data.size() < len + 1 && n < 4000) begin
            tick(); n++;
            if (ren_n - acc_n - out0 > maxo) maxo = ren_n - acc_n - out0;
        end
        repeat (4) tick();
        check("rd_beats", rl_data.size(), len + 1);
        check("rd_ren_pulses", rn_addr.size(), len + 1);
        check("rd_max_buffered_ok", maxo <= DEPTH, 1);
        for (int i = 0; i < rl_data.size() && i <= len; i++) begin
            check($sformatf("rdata[%0d]", i), rl_data[i], ref_get((base + i) & AMASK));
            check($sformatf("rlast[%0d]", i), rl_last[i], i == len);
            check($sformatf("rid[%0d]", i), rl_id[i], id);
            check($sformatf("rresp[%0d]", i), rl_resp[i], 0);
        end
        for (int i = 0; i < rn_addr.size() && i <= len; i++)
            check($sformatf("raddr[%0d]", i), rn_addr[i], (base + i) & AMASK);
        if (consec && rn_cyc.size() == len + 1)
            check("ren_consecutive", rn_cyc[len] - rn_cyc[0], len);
    endtask

    initial begin
        int n;
        int rv0, rn0, ovl0;
        logic [W-1:0] old1;

        // Reset values
        repeat (2) tick();
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_outputs", {wready, bvalid, rvalid, wen, ren}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);
        check("post_rst_outputs", {wready, bvalid, rvalid, wen, ren}, 0);
        tick();

        // Basic 4-beat write then 4-beat read at 0x100
        for (int i = 0; i < 4; i++) begin wd[i] = rnd_word(); ws[i] = '1; end
        axi_write(6'h2A, 32'h100, 3);
        axi_read(6'h15, 32'h100, 3, 1'b1);

        // Partial strobe on beat 1 preserves the upper bytes
        for (int i = 0; i < 2; i++) begin wd[i] = rnd_word(); ws[i] = '1; end
        axi_write(6'h01, 32'h200, 1);
        old1 = wd[1];
        for (int i = 0; i < 2; i++) wd[i] = rnd_word();
        ws[0] = '1; ws[1] = 16'h000F;
        axi_write(6'h02, 32'h200, 1);
        axi_read(6'h03, 32'h200, 1, 1'b0);
        if (rl_data.size() == 2) begin
            check("strb_upper_kept", rl_data[1][W-1:32], old1[W-1:32]);
            check("strb_lower_new", rl_data[1][31:0], wd[1][31:0]);
        end

        // AW and AR in the same cycle to different regions
        for (int i = 0; i < 8; i++) begin wd[i] = rnd_word(); ws[i] = '1; end
        ovl0 = ovl_n;
        fork
            axi_write(6'h05, 32'h1000, 7);
            axi_read(6'h09, 32'h100, 3, 1'b0);
        join
        check("wen_ren_overlap", (ovl_n - ovl0) > 0, 1);
        axi_read(6'h0A, 32'h1000, 7, 1'b0);

        // Longest burst, read back under random backpressure
        for (int i = 0; i < 256; i++) begin wd[i] = rnd_word(); ws[i] = '1; end
        axi_write(6'h3F, 32'h4000, 255);
        rand_rr = 1'b1;
        axi_read(6'h2B, 32'h4000, 255, 1'b0);
        rand_rr = 1'b0;
        repeat (2) tick();

        // Reset in the middle of an 8-beat read burst
        rl_data.delete(); rl_last.delete(); rl_id.delete(); rl_resp.delete();
        arid = 6'h11; araddr = 32'h4000; arlen = 8'd7; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (rl_data.size() < 2 && n < 100) begin tick(); n++; end
        check("mid_rst_beats_before", rl_data.size() >= 2, 1);
        if (rl_data.size() >= 2)
            check("mid_rst_beat1", rl_data[1], ref_get((32'h4000 >> LSB) + 1));
        rst = 1'b1;
        rv0 = rv_n; rn0 = ren_n;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("mid_rst_no_rvalid", rv_n - rv0, 0);
        check("mid_rst_no_ren", ren_n - rn0, 0);
        check("mid_rst_arready", arready, 1);
        check("mid_rst_bvalid", bvalid, 0);
        axi_read(6'h22, 32'h4010, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
